// File: rtl/updn_counter_pkg.sv
// Shared constants and helpers for the up/down counter slice.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package updn_counter_pkg;

  // Boundary behaviour selectors for the SATURATE parameter
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Prescaler counter width: clog2(PRESCALE), never narrower than one bit
  function automatic int presc_width(input int prescale);
    int w;
    w = $clog2(prescale);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/updn_counter_prescaler.sv
// Divides qualified enab cycles by PRESCALE and emits a combinational tick.
// Latency: tick is combinational on the PRESCALE-th enab cycle since the last tick/clear.
// Backpressure: none; enab=0 freezes the accumulated count, clr wins over enab.
module cnt_prescaler
  import updn_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enab,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] pcnt;

  // A tick is the last enab cycle of a prescale window; clr (load) suppresses it
  assign tick = enab && !clr && (pcnt == LAST);

  // Accumulate enab cycles, restart the window on tick or clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (enab) begin
      pcnt <= tick ? '0 : pcnt + ONE;
    end
  end

endmodule

// File: rtl/updn_counter.sv
// Prescaled up/down counter with load, wrap/saturate boundary, tc pulse and sticky ovf.
// Latency: one cycle from load/tick to cnt_out; tc/ovf registered alongside the boundary step.
// Backpressure: none; enab gates counting, load overrides counting on the same edge.
module updn_counter
  import updn_counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enab,
  input  logic             up,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt_out,
  output logic             tc,
  output logic             ovf
);

  localparam longint MAX_LEGAL = (longint'(1) << WIDTH) - 1;

  // Reject illegal configurations at elaboration
  if (MAX_VAL < 1 || longint'(MAX_VAL) > MAX_LEGAL) begin : g_bad_max
    $error("updn_counter: MAX_VAL %0d outside 1..%0d", MAX_VAL, MAX_LEGAL);
  end
  if (PRESCALE < 1) begin : g_bad_presc
    $error("updn_counter: PRESCALE %0d must be >= 1", PRESCALE);
  end
  if (SATURATE != WRAP && SATURATE != SAT) begin : g_bad_sat
    $error("updn_counter: SATURATE %0d must be 0 or 1", SATURATE);
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             tick;
  logic             at_bound;
  logic             boundary;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_cnt;

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .enab (enab),
    .clr  (load),
    .tick (tick)
  );

  // Boundary detection and load clamp; tick already excludes load cycles
  assign at_bound = up ? (cnt_out == MAXV) : (cnt_out == '0);
  assign boundary = tick && at_bound;
  assign load_val = (cnt_in > MAXV) ? MAXV : cnt_in;

  // Next count on a tick: step inside the range, wrap or hold at the boundary
  always_comb begin
    next_cnt = cnt_out;
    if (at_bound) begin
      if (SATURATE == WRAP) begin
        next_cnt = up ? '0 : MAXV;
      end
    end else begin
      next_cnt = up ? (cnt_out + ONE) : (cnt_out - ONE);
    end
  end

  // Counter, tc pulse and sticky ovf; ovf set beats clear, load leaves ovf alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_out <= '0;
      tc      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      tc <= boundary;
      if (load) begin
        cnt_out <= load_val;
      end else if (tick) begin
        cnt_out <= next_cnt;
      end
      if (!load) begin
        if (boundary) begin
          ovf <= 1'b1;
        end else if (clr_ovf) begin
          ovf <= 1'b0;
        end
      end
    end
  end

endmodule
